mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit (HI/LO register pair) for the pipelined CPU's EX stage.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- Exposes busy so the hazard logic stalls later HI/LO consumers; accepts flush from control-hazard logic.
- Generalises the single-cycle datapath to any operand WIDTH, with a cancellable multi-cycle mode.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  input  WIDTH  rt operand (divisor / multiplier)
flush  input  1  abort in-progress operation
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse when hi/lo written by MULT/DIV
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: synchronous, active-high; clk and rst as named above. Reset clears hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Applies mid-operation; the partial result is discarded.
- States: IDLE, RUN.
  - IDLE to RUN: start=1 with op in {MULT, MULTU, DIV, DIVU}. Latch magnitudes, sign flags and op type; counter=0.
  - RUN to IDLE: counter reaches WIDTH-1 on that edge, or flush=1.
- Latency: start sampled at edge E0. busy=1 from after E0 through edge E0+WIDTH. At edge E0+WIDTH hi/lo are written, busy returns to 0 and done=1 for exactly one cycle. Total is WIDTH cycles, one result bit per cycle.
- Multiply (radix-2 shift-add on magnitudes):
  - signed: operands are negated if negative; the 2*WIDTH product is negated if the signs differ.
  - result: {hi, lo} = product.
- Divide (restoring, on magnitudes):
  - lo = quotient, hi = remainder.
  - signed: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - b=0: lo = all ones, hi = a (signed and unsigned alike); no exception.
  - signed MIN / -1: lo = MIN, hi = 0, no error. This falls out of the magnitude arithmetic.
- MTHI/MTLO: in IDLE, start=1 writes hi or lo from a at the same edge. busy stays 0, done stays 0.
- Register hold: hi/lo hold their previous values throughout RUN and change only at completion.
- start while busy=1: ignored (no queueing). The requester must hold start until busy=0.
- flush in RUN: return to IDLE at that edge; hi/lo unchanged; done=0.
- flush in IDLE: no effect, except that start in the same cycle is suppressed (flush wins).
- Back-to-back: a new start is accepted in the done cycle, since busy=0 then.
- No-op codes 11x: ignored, state unchanged.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU compute with a combinational WIDTH x WIDTH multiply.
  - hi/lo are written at the start edge, busy stays 0, done=1 in the following cycle.
  - Divide is unchanged and iterative.
- MDU_FAST_MUL_EN undefined: multiply is iterative as described above, WIDTH cycles.

Decomposition:
- Shared encoding header (alongside the control encode definitions): op codes MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, and the state encodings MDU_IDLE, MDU_RUN.
- One sub-module, mdu_div_step: a combinational restoring-division step. Inputs are partial remainder, quotient and divisor; outputs are the next remainder and quotient. It is parameterised by WIDTH and instantiated once in mdu_iter.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, single-cycle done.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MDU_FAST_MUL_EN: same values, busy never asserted, done next cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then MTHI a=0x1234 -> hi=0x1234 at the next edge, busy=0.
- Preload hi=0xAA, lo=0xBB; DIVU 100/3; start during busy with op=MTLO is ignored; flush on cycle 10 -> busy=0 next cycle, hi=0xAA, lo=0xBB, no done.
- MULTU in progress, rst=1 on cycle 5 -> next edge: hi=lo=0, busy=0, done=0. A fresh start is then accepted normally.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM state encoding and small op-decode helpers.
package mdu_iter_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU all share op[2]=0
  function automatic logic mdu_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // signed variants are the even codes of the arithmetic group
  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
// The dividend bits live in the quotient register and are consumed MSB first.
module mdu_div_step
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // trial subtraction; remainder restored by simply not taking the difference
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    if (shifted >= {1'b0, div_i}) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO register pair.
// Multiply: radix-2 shift-add on magnitudes; divide: restoring on magnitudes.
// Both take WIDTH cycles and share the acc_hi/acc_lo working registers.
// Build option MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle combinational
// multiplier and never raise busy; divide stays iterative.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MDU_IDLE | waiting; accepts MULT/MULTU/DIV/DIVU launch and MTHI/MTLO
// MDU_RUN  | one result bit per cycle; completes after WIDTH steps
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH-1:0] div_rem_n, div_quo_n;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_hi_q),
    .quo_i (acc_lo_q),
    .div_i (opnd_q),
    .rem_o (div_rem_n),
    .quo_o (div_quo_n)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;

  // extend to 2*WIDTH first so the truncated product is correct signed or not
  always_comb begin
    fast_a    = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    fast_b    = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    fast_prod = fast_a * fast_b;
  end
`endif

  // operand magnitudes, iteration datapath and sign fix-up of the final step
  always_comb begin
    op_signed = mdu_is_signed(op);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    step_hi   = is_div_q ? div_rem_n : mul_hi_n;
    step_lo   = is_div_q ? div_quo_n : mul_lo_n;

    prod_mag  = {step_hi, step_lo};
    prod_fix  = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
    // divide-by-zero: quotient forced to all ones; remainder magnitude is |a|,
    // which the dividend-sign fix-up turns back into a
    quo_fix   = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? (~step_lo + 1'b1) : step_lo);
    rem_fix   = neg_rem_q ? (~step_hi + 1'b1) : step_hi;

    res_hi    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // next-state logic: launch, iterate, complete or abort
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        if (start && !flush) begin
          if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end else if (mdu_is_arith(op)) begin
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) begin
              hi_d   = fast_prod[2*WIDTH-1:WIDTH];
              lo_d   = fast_prod[WIDTH-1:0];
              done_d = 1'b1;
            end else begin
`else
            begin
`endif
              state_d   = MDU_RUN;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              dz_d      = op[1] && (b == '0);
              acc_hi_d  = '0;
              // divide: dividend shifts out of acc_lo; multiply: multiplier does
              acc_lo_d  = op[1] ? a_mag : b_mag;
              opnd_d    = op[1] ? b_mag : a_mag;
            end
          end
        end
      end
      MDU_RUN: begin
        if (flush) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == MDU_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
